// File: rtl/ram_loader.sv
// Program-RAM loader: streams DEPTH bytes into the RAM in address order, then
// optionally reads every location back and compares it against a shadow copy.
module ram_loader #(
    parameter int DEPTH  = 16,
    parameter bit VERIFY = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic       load_valid,
    input  logic [7:0] load_data,
    output logic       load_ready,
    output logic [3:0] mem_address,
    output logic       ri,
    output logic       ro,
    output logic [7:0] ram_wdata,
    input  logic [7:0] ram_rdata,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [3:0] err_addr
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LOAD   = 2'd1;
    localparam logic [1:0] S_VERIFY = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    localparam logic [3:0] LAST = 4'(DEPTH - 1);

    logic [1:0] state;
    logic [3:0] addr;
    logic [7:0] shadow [16];
    logic       accept;
    logic       mismatch;

    // Every strobe is a decode of the state register, so an async reset of
    // state alone drives all outputs to their idle values immediately.
    assign load_ready  = (state == S_LOAD);
    assign ro          = (state == S_VERIFY);
    assign done        = (state == S_DONE);
    assign busy        = load_ready | ro;
    assign accept      = load_ready & load_valid;
    assign ri          = accept;
    assign ram_wdata   = accept ? load_data : 8'h00;
    assign mem_address = addr;

    // RAM read data is combinational, so it is checked in the same cycle ro is up.
    assign mismatch = ro && (ram_rdata != shadow[addr]);

    always_ff @(posedge clk) begin
        if (accept)
            shadow[addr] <= load_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            addr     <= 4'd0;
            error    <= 1'b0;
            err_addr <= 4'd0;
        end else if (abort) begin
            state    <= S_IDLE;
            addr     <= 4'd0;
            error    <= 1'b0;
            err_addr <= 4'd0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state    <= S_LOAD;
                        addr     <= 4'd0;
                        error    <= 1'b0;
                        err_addr <= 4'd0;
                    end
                end
                S_LOAD: begin
                    if (accept) begin
                        if (addr == LAST) begin
                            if (VERIFY) begin
                                state <= S_VERIFY;
                                addr  <= 4'd0;
                            end else begin
                                state <= S_DONE;
                                addr  <= addr + 4'd1;
                            end
                        end else begin
                            addr <= addr + 4'd1;
                        end
                    end
                end
                S_VERIFY: begin
                    // Only the first mismatch is recorded; the scan always runs to the end.
                    if (mismatch && !error) begin
                        error    <= 1'b1;
                        err_addr <= addr;
                    end
                    addr <= addr + 4'd1;
                    if (addr == LAST)
                        state <= S_DONE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_loader.sv
// Bench for ram_loader: a 16-deep verifying instance and a 4-deep load-only
// instance, each attached to a behavioural RAM, checked against stream-level expectations.
module tb_ram_loader;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Instance A: DEPTH=16, VERIFY=1
    logic       a_start = 0, a_abort = 0, a_valid = 0;
    logic [7:0] a_data = 0, a_wdata, a_rdata;
    logic       a_load_ready, a_ri, a_ro, a_busy, a_done, a_error;
    logic [3:0] a_mem_address, a_err_addr;

    // Instance B: DEPTH=4, VERIFY=0
    logic       b_start = 0, b_abort = 0, b_valid = 0;
    logic [7:0] b_data = 0, b_wdata, b_rdata;
    logic       b_load_ready, b_ri, b_ro, b_busy, b_done, b_error;
    logic [3:0] b_mem_address, b_err_addr;

    ram_loader #(.DEPTH(16), .VERIFY(1'b1)) dut_a (
        .clk(clk), .rst(rst), .start(a_start), .abort(a_abort),
        .load_valid(a_valid), .load_data(a_data), .load_ready(a_load_ready),
        .mem_address(a_mem_address), .ri(a_ri), .ro(a_ro), .ram_wdata(a_wdata),
        .ram_rdata(a_rdata), .busy(a_busy), .done(a_done), .error(a_error),
        .err_addr(a_err_addr));

    ram_loader #(.DEPTH(4), .VERIFY(1'b0)) dut_b (
        .clk(clk), .rst(rst), .start(b_start), .abort(b_abort),
        .load_valid(b_valid), .load_data(b_data), .load_ready(b_load_ready),
        .mem_address(b_mem_address), .ri(b_ri), .ro(b_ro), .ram_wdata(b_wdata),
        .ram_rdata(b_rdata), .busy(b_busy), .done(b_done), .error(b_error),
        .err_addr(b_err_addr));

    // Behavioural RAMs; A can corrupt reads of addresses 5 and 9.
    logic [7:0] ram_a [16];
    logic [7:0] ram_b [16];
    logic       corrupt = 1'b0;
    logic [7:0] stream [16];

    always @(posedge clk) begin
        if (a_ri) ram_a[a_mem_address] <= a_wdata;
        if (b_ri) ram_b[b_mem_address] <= b_wdata;
    end
    assign a_rdata = ram_a[a_mem_address] ^
        ((corrupt && (a_mem_address == 4'd5 || a_mem_address == 4'd9)) ? 8'hFF : 8'h00);
    assign b_rdata = ram_b[b_mem_address];

    task automatic test_reset();
        #3;
        n_cmp++;
        if ({a_ri, a_ro, a_load_ready, a_busy, a_done, a_error, a_err_addr, a_mem_address, a_wdata} !== 24'd0)
            begin n_err++; $display("FAIL reset_a outputs got %b want 0", {a_ri, a_ro, a_load_ready, a_busy, a_done, a_error, a_err_addr, a_mem_address, a_wdata}); end
        n_cmp++;
        if ({b_ri, b_ro, b_load_ready, b_busy, b_done, b_error, b_err_addr, b_mem_address, b_wdata} !== 24'd0)
            begin n_err++; $display("FAIL reset_b outputs got %b want 0", {b_ri, b_ro, b_load_ready, b_busy, b_done, b_error, b_err_addr, b_mem_address, b_wdata}); end
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // mode 0: always valid, bytes 0x10+k; 1: valid on even cycles; 2: random valid.
    task automatic run_a(input int mode, input bit corrupt_en, input string name);
        int k = 0, c = 1, done_cyc = 0, last_acc = 0, ro_cnt = 0, bad = 0;
        bit v;
        for (int i = 0; i < 16; i++)
            stream[i] = (mode == 0) ? 8'(8'h10 + i) : 8'($urandom);
        corrupt = corrupt_en;
        a_start = 1'b1;
        @(posedge clk); #1;
        a_start = 1'b0;
        while (done_cyc == 0 && c < 200) begin
            v = (mode == 0) ? 1'b1 : (mode == 1) ? (c % 2 == 0) : 1'($urandom_range(0, 1));
            a_valid = v;
            a_data  = (v && k < 16) ? stream[k] : 8'($urandom);
            #1;
            if (a_done) begin
                done_cyc = c;
            end else if (k < 16) begin
                n_cmp++;
                if (a_ri !== v || a_load_ready !== 1'b1 || a_ro !== 1'b0 || a_busy !== 1'b1 ||
                    a_mem_address !== 4'(k) || a_wdata !== (v ? stream[k] : 8'h00)) begin
                    n_err++;
                    $display("FAIL %s load c%0d got ri=%b rdy=%b ro=%b busy=%b a=%0d wd=%h want ri=%b rdy=1 ro=0 busy=1 a=%0d wd=%h",
                             name, c, a_ri, a_load_ready, a_ro, a_busy, a_mem_address, a_wdata, v, k, v ? stream[k] : 8'h00);
                end
                if (v) begin k++; last_acc = c; end
            end else begin
                n_cmp++;
                if (a_ro !== 1'b1 || a_ri !== 1'b0 || a_load_ready !== 1'b0 || a_busy !== 1'b1 ||
                    a_mem_address !== 4'(ro_cnt)) begin
                    n_err++;
                    $display("FAIL %s verify c%0d got ro=%b ri=%b rdy=%b busy=%b a=%0d want ro=1 ri=0 rdy=0 busy=1 a=%0d",
                             name, c, a_ro, a_ri, a_load_ready, a_busy, a_mem_address, ro_cnt[3:0]);
                end
                ro_cnt++;
            end
            @(posedge clk); #1;
            c++;
        end
        a_valid = 1'b0;
        n_cmp++;
        if (done_cyc !== last_acc + 17)
            begin n_err++; $display("FAIL %s done_cycle got %0d want %0d", name, done_cyc, last_acc + 17); end
        n_cmp++;
        if (ro_cnt !== 16)
            begin n_err++; $display("FAIL %s verify_cycles got %0d want 16", name, ro_cnt); end
        n_cmp++;
        if ({a_error, a_err_addr} !== {corrupt_en, corrupt_en ? 4'd5 : 4'd0})
            begin n_err++; $display("FAIL %s error got %b/%0d want %b/%0d", name, a_error, a_err_addr, corrupt_en, corrupt_en ? 5 : 0); end
        for (int i = 0; i < 16; i++) if (ram_a[i] !== stream[i]) bad++;
        n_cmp++;
        if (bad != 0)
            begin n_err++; $display("FAIL %s ram_contents got %0d bad words want 0", name, bad); end
        @(posedge clk); #1;
        n_cmp++;
        if ({a_done, a_busy, a_ri, a_ro, a_error} !== {3'b100, 1'b0, corrupt_en})
            begin n_err++; $display("FAIL %s done_hold got d=%b b=%b ri=%b ro=%b e=%b want d=1 b=0 ri=0 ro=0 e=%b", name, a_done, a_busy, a_ri, a_ro, a_error, corrupt_en); end
        corrupt = 1'b0;
    endtask

    task automatic test_abort_clears_error();
        a_abort = 1'b1;
        @(posedge clk); #1;
        a_abort = 1'b0;
        #1;
        n_cmp++;
        if ({a_error, a_err_addr, a_done, a_busy} !== 7'd0)
            begin n_err++; $display("FAIL abort_clear got e=%b ea=%0d d=%b b=%b want 0", a_error, a_err_addr, a_done, a_busy); end
    endtask

    task automatic test_abort();
        a_start = 1'b1;
        @(posedge clk); #1;
        a_start = 1'b0;
        for (int i = 0; i < 7; i++) begin
            a_valid = 1'b1; a_data = 8'($urandom);
            @(posedge clk); #1;
        end
        a_abort = 1'b1; a_start = 1'b1; a_valid = 1'b1;
        #1;
        n_cmp++;
        if (a_mem_address !== 4'd7 || a_load_ready !== 1'b1)
            begin n_err++; $display("FAIL abort_at7 got a=%0d rdy=%b want a=7 rdy=1", a_mem_address, a_load_ready); end
        @(posedge clk); #1;
        a_abort = 1'b0; a_start = 1'b0;
        #1;
        n_cmp++;
        if ({a_ri, a_ro, a_load_ready, a_busy, a_done, a_error, a_mem_address} !== 10'd0)
            begin n_err++; $display("FAIL abort_idle got %b want 0", {a_ri, a_ro, a_load_ready, a_busy, a_done, a_error, a_mem_address}); end
        @(posedge clk); #1;
        n_cmp++;
        if (a_load_ready !== 1'b0 || a_busy !== 1'b0)
            begin n_err++; $display("FAIL abort_start_ignored got rdy=%b busy=%b want 0/0", a_load_ready, a_busy); end
        a_valid = 1'b0; a_start = 1'b1;
        @(posedge clk); #1;
        a_start = 1'b0;
        n_cmp++;
        if (a_load_ready !== 1'b1 || a_mem_address !== 4'd0 || a_busy !== 1'b1)
            begin n_err++; $display("FAIL abort_restart got rdy=%b a=%0d busy=%b want 1/0/1", a_load_ready, a_mem_address, a_busy); end
        a_abort = 1'b1;
        @(posedge clk); #1;
        a_abort = 1'b0;
    endtask

    task automatic test_async_reset();
        a_start = 1'b1;
        @(posedge clk); #1;
        a_start = 1'b0; a_valid = 1'b1; a_data = 8'h5A;
        repeat (3) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({a_ri, a_ro, a_load_ready, a_busy, a_done, a_error, a_err_addr, a_mem_address, a_wdata} !== 24'd0)
            begin n_err++; $display("FAIL async_reset got %b want 0", {a_ri, a_ro, a_load_ready, a_busy, a_done, a_error, a_err_addr, a_mem_address, a_wdata}); end
        a_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_depth4();
        int c = 1, wr = 0, done_cyc = 0;
        bit ro_seen = 0;
        b_start = 1'b1;
        @(posedge clk); #1;
        b_start = 1'b0;
        while (done_cyc == 0 && c < 50) begin
            b_valid = 1'b1;
            b_data  = 8'(8'hA1 + wr);
            #1;
            if (b_ro) ro_seen = 1'b1;
            if (b_done) begin
                done_cyc = c;
            end else begin
                n_cmp++;
                if (b_ri !== 1'b1 || b_mem_address !== 4'(wr) || b_wdata !== 8'(8'hA1 + wr))
                    begin n_err++; $display("FAIL d4_write c%0d got ri=%b a=%0d wd=%h want ri=1 a=%0d wd=%h", c, b_ri, b_mem_address, b_wdata, wr, 8'(8'hA1 + wr)); end
                wr++;
            end
            @(posedge clk); #1;
            c++;
        end
        b_valid = 1'b0;
        n_cmp++;
        if (done_cyc !== 5 || ro_seen)
            begin n_err++; $display("FAIL d4_done got cycle=%0d ro_seen=%b want 5/0", done_cyc, ro_seen); end
        n_cmp++;
        if ({ram_b[0], ram_b[1], ram_b[2], ram_b[3]} !== 32'hA1A2A3A4)
            begin n_err++; $display("FAIL d4_ram got %h want a1a2a3a4", {ram_b[0], ram_b[1], ram_b[2], ram_b[3]}); end
        b_start = 1'b1;
        @(posedge clk); #1;
        b_start = 1'b0;
        n_cmp++;
        if (b_done !== 1'b0 || b_load_ready !== 1'b1 || b_mem_address !== 4'd0)
            begin n_err++; $display("FAIL d4_restart got d=%b rdy=%b a=%0d want 0/1/0", b_done, b_load_ready, b_mem_address); end
        b_abort = 1'b1;
        @(posedge clk); #1;
        b_abort = 1'b0;
    endtask

    initial begin
        test_reset();
        run_a(0, 1'b0, "full_load");
        run_a(1, 1'b0, "stalled");
        run_a(2, 1'b0, "random_stall");
        run_a(2, 1'b1, "verify_fault");
        test_abort_clears_error();
        test_abort();
        run_a(0, 1'b0, "after_abort");
        test_async_reset();
        test_depth4();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
